z88_vga_scan: RTL

- Raster-side reader of the LCD VRAM: generates 640x480@60 VGA timing from the 50 MHz master clock and fetches 3-bit VRAM entries.
- Each entry holds {gray, left pixel, right pixel}. The block converts entries to 4-bit-per-channel RGB.
- Emits the new_fr_tgl frame toggle that triggers the LCD fetch engine, which rewrites the VRAM during vertical non-display time.

---
 rtl/z88_vga_scan.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/z88_vga_scan.sv
// z88_vga_scan: 640x480@60 raster timing from the 50 MHz clock, LCD VRAM fetch and 12-bit colour.
// Optional: define Z88_VGA_SCANLINE_EN to halve the colour on every fourth window line.
module z88_vga_scan #(
   parameter int H_ACT  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYN  = 96,
   parameter int H_BP   = 48,
   parameter int V_ACT  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYN  = 2,
   parameter int V_BP   = 33,
   parameter int WIN_V0 = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_on,
   output logic [14:0] vram_rd_addr,
   input  logic [2:0]  vram_rd_data,
   output logic        new_fr_tgl,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;

   localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
   localparam logic [9:0] H_ACT_END = 10'(H_ACT);
   localparam logic [9:0] V_ACT_END = 10'(V_ACT);
   localparam logic [9:0] HS_BEG    = 10'(H_ACT + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_ACT + H_FP + H_SYN);
   localparam logic [9:0] VS_BEG    = 10'(V_ACT + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_ACT + V_FP + V_SYN);
   localparam logic [9:0] WIN_BEG   = 10'(WIN_V0);
   localparam logic [9:0] WIN_END   = 10'(WIN_V0 + 256);
   localparam logic [9:0] TGL_LINE  = 10'(WIN_V0 + 255);

   localparam logic [11:0] RGB_BG       = 12'hCDB;
   localparam logic [11:0] RGB_PIX      = 12'h212;
   localparam logic [11:0] RGB_PIX_GRAY = 12'h878;

   logic        pix_ena_reg;
   logic [9:0]  h_ctr_reg;
   logic [9:0]  v_ctr_reg;
   logic        h_last;
   logic        v_last;
   logic        de_s0;
   logic        hs_s0;
   logic        vs_s0;
   logic        win_s0;
   logic        hs_s1_reg;
   logic        vs_s1_reg;
   logic        de_s1_reg;
   logic        win_s1_reg;
   logic        h0_s1_reg;
   logic        lcd_on_reg;
   logic        pix_bit;
   logic [11:0] rgb_base;
   logic [11:0] rgb_next;
   logic [11:0] rgb_reg;

   always_comb begin
      h_last = (h_ctr_reg == H_LAST);
      v_last = (v_ctr_reg == V_LAST);
      de_s0  = (h_ctr_reg < H_ACT_END) && (v_ctr_reg < V_ACT_END);
      hs_s0  = (h_ctr_reg >= HS_BEG) && (h_ctr_reg < HS_END);
      vs_s0  = (v_ctr_reg >= VS_BEG) && (v_ctr_reg < VS_END);
      win_s0 = (h_ctr_reg < H_ACT_END) && (v_ctr_reg >= WIN_BEG) && (v_ctr_reg < WIN_END);
   end

   // vram_rd_data belongs to the address issued one pixel earlier, i.e. to stage 1
   always_comb begin
      pix_bit  = h0_s1_reg ? vram_rd_data[0] : vram_rd_data[1];
      rgb_base = 12'h000;
      if (win_s1_reg) begin
         if (!lcd_on_reg || !pix_bit)
            rgb_base = RGB_BG;
         else if (vram_rd_data[2])
            rgb_base = RGB_PIX_GRAY;
         else
            rgb_base = RGB_PIX;
      end
   end

`ifdef Z88_VGA_SCANLINE_EN
   logic        dim_s1_reg;
   logic [11:0] rgb_dim;
   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_dim
      assign rgb_dim[gi*4 +: 4] = {1'b0, rgb_base[gi*4+1 +: 3]};
   end
   assign rgb_next = dim_s1_reg ? rgb_dim : rgb_base;
`else
   assign rgb_next = rgb_base;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_ena_reg  <= 1'b0;
         h_ctr_reg    <= '0;
         v_ctr_reg    <= '0;
         vram_rd_addr <= '0;
         hs_s1_reg    <= 1'b1;
         vs_s1_reg    <= 1'b1;
         de_s1_reg    <= 1'b0;
         win_s1_reg   <= 1'b0;
         h0_s1_reg    <= 1'b0;
         lcd_on_reg   <= 1'b0;
         new_fr_tgl   <= 1'b0;
         vga_hs       <= 1'b1;
         vga_vs       <= 1'b1;
         vga_de       <= 1'b0;
         rgb_reg      <= '0;
`ifdef Z88_VGA_SCANLINE_EN
         dim_s1_reg   <= 1'b0;
`endif
      end else begin
         pix_ena_reg <= ~pix_ena_reg;
         if (pix_ena_reg) begin
            if (h_last) begin
               h_ctr_reg <= '0;
               v_ctr_reg <= v_last ? '0 : v_ctr_reg + 10'd1;
               // flips as the counters enter the first line below the window
               if (v_ctr_reg == TGL_LINE)
                  new_fr_tgl <= ~new_fr_tgl;
            end else begin
               h_ctr_reg <= h_ctr_reg + 10'd1;
            end
            if ((h_ctr_reg == '0) && (v_ctr_reg == '0))
               lcd_on_reg <= lcd_on;
            if (win_s0)
               vram_rd_addr <= {h_ctr_reg[9:1], v_ctr_reg[7:2]};
            hs_s1_reg  <= ~hs_s0;
            vs_s1_reg  <= ~vs_s0;
            de_s1_reg  <= de_s0;
            win_s1_reg <= win_s0;
            h0_s1_reg  <= h_ctr_reg[0];
`ifdef Z88_VGA_SCANLINE_EN
            dim_s1_reg <= (v_ctr_reg[1:0] == 2'b11);
`endif
            vga_hs  <= hs_s1_reg;
            vga_vs  <= vs_s1_reg;
            vga_de  <= de_s1_reg;
            rgb_reg <= rgb_next;
         end
      end
   end

   assign vga_r = rgb_reg[11:8];
   assign vga_g = rgb_reg[7:4];
   assign vga_b = rgb_reg[3:0];

endmodule
